// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI slave.
//   - spi_state_t : receive/transmit FSM states
//   - WR_ADDR/WR_DATA/RD_ADDR/RD_DATA : 2-bit command codes carried in the frame MSBs
//   - frame_width(): full frame width (command field + payload)
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_t;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    function automatic int frame_width(input int data_w, input int cmd_w);
        return data_w + cmd_w;
    endfunction

endpackage

// File: rtl/spi_slave_param_tx.sv
// spi_tx_serialiser: parallel-load, MSB-first shifter feeding MISO.
//   clk, rst : clock and asynchronous active-high reset
//   load     : capture data; data[DATA_W-1] appears on miso the next cycle
//   abort    : drop any transfer in progress, miso returns to 0
//   data     : parallel word to transmit
//   miso     : registered serial output, 0 when idle
//   done     : high during the cycle the last bit is on miso
module spi_tx_serialiser #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              abort,
    input  logic [DATA_W-1:0] data,
    output logic              miso,
    output logic              done
);

    localparam int TCNT_W = $clog2(DATA_W + 1);
    localparam logic [TCNT_W-1:0] CNT_ONE  = TCNT_W'(1);
    localparam logic [TCNT_W-1:0] CNT_LAST = TCNT_W'(DATA_W);

    logic [DATA_W-1:0] shift_reg;
    logic [TCNT_W-1:0] cnt_reg;     // bits already placed on miso
    logic              busy_reg;
    logic              miso_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            miso_reg  <= 1'b0;
        end else if (abort) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            miso_reg  <= 1'b0;
        end else if (load) begin
            miso_reg  <= data[DATA_W-1];
            shift_reg <= data << 1;
            cnt_reg   <= CNT_ONE;
            busy_reg  <= 1'b1;
        end else if (busy_reg) begin
            if (cnt_reg == CNT_LAST) begin
                miso_reg <= 1'b0;
                busy_reg <= 1'b0;
                cnt_reg  <= '0;
            end else begin
                miso_reg  <= shift_reg[DATA_W-1];
                shift_reg <= shift_reg << 1;
                cnt_reg   <= cnt_reg + CNT_ONE;
            end
        end
    end

    assign miso = miso_reg;
    assign done = busy_reg && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave between an external master and the RAM controller.
// Receives DATA_W+2 bit frames MSB-first on MOSI ({cmd[1:0], payload}) and
// presents them on rx_data with a one-cycle rx_valid strobe. A read-address
// frame arms read_flag; the following frame is a read-data frame, after which
// tx_data (captured on tx_valid) is shifted out MSB-first on MISO.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   SS_n, MOSI        : slave select (active-low), serial in
//   tx_data, tx_valid : RAM read data and its strobe
//   MISO              : serial out, 0 when not transmitting
//   rx_data, rx_valid : received frame and its one-cycle strobe
//   frame_err         : only when SPI_FRAME_ERR_EN is defined; one-cycle pulse
//                       when SS_n rises before a frame or a transmit completes
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CMD_W  = 2,
    localparam int FRAME_W = frame_width(DATA_W, CMD_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               SS_n,
    input  logic               MOSI,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic               frame_err
`endif
);

    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] FRAME_DONE = CNT_W'(FRAME_W);

    spi_state_t         state_reg, state_next;
    logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;     // frame bits received so far
    logic [FRAME_W-2:0] shift_reg, shift_next;         // last bit comes straight from MOSI
    logic [FRAME_W-1:0] rx_data_reg, rx_data_next;
    logic               rx_valid_reg, rx_valid_next;
    logic               read_flag_reg, read_flag_next;
    logic               tx_started_reg, tx_started_next; // one TX per read-data frame
    logic               tx_load;
    logic               tx_abort;
    logic               tx_done;

    assign tx_abort = SS_n && (state_reg != IDLE);

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        rx_data_next    = rx_data_reg;
        rx_valid_next   = 1'b0;
        read_flag_next  = read_flag_reg;
        tx_started_next = tx_started_reg;
        tx_load         = 1'b0;

        if (state_reg == IDLE) begin
            bit_cnt_next = '0;
            if (!SS_n) begin
                state_next = CHK_CMD;
            end
        end else if (SS_n) begin
            // Abort: discard the partial frame; read_flag is kept so an
            // interrupted read pair can be retried.
            state_next      = IDLE;
            bit_cnt_next    = '0;
            shift_next      = '0;
            tx_started_next = 1'b0;
        end else begin
            case (state_reg)
                CHK_CMD: begin
                    shift_next   = {{(FRAME_W-2){1'b0}}, MOSI};
                    bit_cnt_next = CNT_ONE;
                    if (!MOSI) begin
                        state_next = WRITE;
                    end else if (read_flag_reg) begin
                        state_next = READ_DATA;
                    end else begin
                        state_next = READ_ADD;
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    // Counter parks at FRAME_DONE, so trailing MOSI bits are ignored.
                    if (bit_cnt_reg != FRAME_DONE) begin
                        shift_next   = {shift_reg[FRAME_W-3:0], MOSI};
                        bit_cnt_next = bit_cnt_reg + CNT_ONE;
                        if (bit_cnt_reg == LAST_BIT) begin
                            rx_data_next  = {shift_reg, MOSI};
                            rx_valid_next = 1'b1;
                            if (state_reg == READ_ADD) begin
                                read_flag_next = 1'b1;
                            end
                        end
                    end
                    if (state_reg == READ_DATA && bit_cnt_reg == FRAME_DONE &&
                        !tx_started_reg && tx_valid) begin
                        tx_load         = 1'b1;
                        tx_started_next = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        // The address/data pair is consumed once the last data bit is on MISO.
        if (tx_done) begin
            read_flag_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            read_flag_reg  <= 1'b0;
            tx_started_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            rx_data_reg    <= rx_data_next;
            rx_valid_reg   <= rx_valid_next;
            read_flag_reg  <= read_flag_next;
            tx_started_reg <= tx_started_next;
        end
    end

    spi_tx_serialiser #(
        .DATA_W (DATA_W)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .load  (tx_load),
        .abort (tx_abort),
        .data  (tx_data),
        .miso  (MISO),
        .done  (tx_done)
    );

    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;

`ifdef SPI_FRAME_ERR_EN
    logic frame_err_reg, frame_err_next;

    // A transmit is in flight while tx_started and read_flag are both set
    // (read_flag drops once the final bit has been driven).
    always_comb begin
        frame_err_next = 1'b0;
        if (SS_n && (state_reg == WRITE || state_reg == READ_ADD || state_reg == READ_DATA)) begin
            if (bit_cnt_reg != FRAME_DONE ||
                (tx_started_reg && read_flag_reg && !tx_done)) begin
                frame_err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= frame_err_next;
        end
    end

    assign frame_err = frame_err_reg;
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// Testbench for spi_slave_param (DATA_W = 8). Expected rx frames and MISO bits
// are queued when stimulus is driven and compared by a negedge monitor.
module tb_spi_slave_param;
    import spi_pkg::*;

    localparam int DATA_W  = 8;
    localparam int FRAME_W = 10;

    logic               clk = 1'b0;
    logic               rst;
    logic               SS_n;
    logic               MOSI;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
`ifdef SPI_FRAME_ERR_EN
    logic               frame_err;
    int                 err_pulses = 0;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int rx_pulses   = 0;

    logic [FRAME_W-1:0] rx_q[$];
    logic               miso_q[$];

    always #5 clk = ~clk;

    spi_slave_param #(
        .DATA_W (DATA_W),
        .CMD_W  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Scoreboard monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_pulses++;
            if (rx_q.size() == 0) begin
                check_val("rx_spurious", rx_q.size(), 1);
            end else begin
                check_val("rx_data", rx_data, rx_q.pop_front());
            end
        end
        if (miso_q.size() != 0) begin
            check_val("miso", MISO, miso_q.pop_front());
        end
`ifdef SPI_FRAME_ERR_EN
        if (frame_err) err_pulses++;
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One IDLE cycle with SS_n low, then nbits frame bits MSB-first.
    task automatic send_frame(input logic [FRAME_W-1:0] frame, input int nbits);
        SS_n = 1'b0;
        MOSI = 1'b0;
        tick();
        for (int i = 0; i < nbits; i++) begin
            MOSI = frame[FRAME_W-1-i];
            if (i == FRAME_W - 1) rx_q.push_back(frame);
            tick();
        end
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
    endtask

    task automatic push_byte(input logic [DATA_W-1:0] b);
        for (int i = DATA_W - 1; i >= 0; i--) miso_q.push_back(b[i]);
    endtask

    initial begin
        rst      = 1'b1;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        repeat (3) tick();
        check_val("reset_state", dut.state_reg, IDLE);
        check_val("reset_rx_valid", rx_valid, 0);
        check_val("reset_miso", MISO, 0);
        check_val("reset_rx_data", rx_data, 0);
        rst = 1'b0;
        tick();

        // Write frame, then trailing bits that must be ignored.
        send_frame(10'h0A5, FRAME_W);
        for (int i = 0; i < 3; i++) begin
            MOSI = 1'($urandom_range(0, 1));
            tick();
        end
        check_val("write_hold_state", dut.state_reg, WRITE);
        check_val("write_pulses", rx_pulses, 1);
        end_frame();
        check_val("write_abort_idle", dut.state_reg, IDLE);

        // Back-to-back write after one SS_n-high cycle; tx_valid ignored here.
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        send_frame(10'h0C3, FRAME_W);
        tick();
        check_val("write_tx_ignored", MISO, 0);
        tx_valid = 1'b0;
        end_frame();
        check_val("b2b_pulses", rx_pulses, 2);

        // Read address frame arms read_flag.
        send_frame(10'h20F, FRAME_W);
        check_val("rdaddr_state", dut.state_reg, READ_ADD);
        tick();
        end_frame();
        check_val("rdaddr_flag", dut.read_flag_reg, 1);
        check_val("rdaddr_pulses", rx_pulses, 3);

        // Read data frame, TX aborted after three bits: flag retained.
        send_frame(10'h300, FRAME_W);
        check_val("rddata_state", dut.state_reg, READ_DATA);
        tick();
        check_val("rddata_wait_miso", MISO, 0);
        tx_data  = 8'hC6;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        miso_q.push_back(1'b1);
        miso_q.push_back(1'b1);
        miso_q.push_back(1'b0);
        miso_q.push_back(1'b0);
        tick();
        tick();
        end_frame();
        tick();
        check_val("txabort_flag", dut.read_flag_reg, 1);
        check_val("txabort_q_drained", miso_q.size(), 0);

        // Retry of the read data frame with a complete transmit.
        send_frame(10'h300, FRAME_W);
        check_val("retry_state", dut.state_reg, READ_DATA);
        tick();
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        push_byte(8'h5A);
        miso_q.push_back(1'b0);
        repeat (DATA_W) tick();
        // A second tx_valid in the same frame must not restart TX.
        tx_valid = 1'b1;
        repeat (3) miso_q.push_back(1'b0);
        repeat (3) tick();
        tx_valid = 1'b0;
        tick();
        check_val("tx_done_flag", dut.read_flag_reg, 0);
        check_val("tx_q_drained", miso_q.size(), 0);
        end_frame();
        check_val("read_pulses", rx_pulses, 5);

        // Write frame aborted after four bits.
        send_frame(10'h155, 4);
        end_frame();
        check_val("abort_idle", dut.state_reg, IDLE);
        repeat (2) tick();
        check_val("abort_no_pulse", rx_pulses, 5);
        check_val("abort_flag_kept", dut.read_flag_reg, 0);
`ifdef SPI_FRAME_ERR_EN
        check_val("frame_err_pulses", err_pulses, 2);
`endif

        // Reset while in WRITE with five bits received.
        send_frame(10'h0FF, 5);
        check_val("pre_reset_cnt", dut.bit_cnt_reg, 5);
        rst = 1'b1;
        #1;
        check_val("midrst_state", dut.state_reg, IDLE);
        check_val("midrst_rx_valid", rx_valid, 0);
        check_val("midrst_miso", MISO, 0);
        check_val("midrst_rx_data", rx_data, 0);
        tick();
        rst  = 1'b0;
        SS_n = 1'b1;
        repeat (2) tick();

        check_val("rx_q_empty", rx_q.size(), 0);
        check_val("miso_q_empty", miso_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
